aes_inv_key_sched: RTL and testbench

Decryption-side key supplier for the AES-128 datapath. It captures the 128-bit cipher key on a start pulse and expands it forward, one round key per cycle, into an 11-entry round-key store. On request it streams the keys back in reverse order (round 10 down to round 0), which is the order the inverse rounds consume them. It sits beside the decryption core, with the encryption core's key schedule as its forward-order counterpart.

---
 rtl/aes_pkg.sv | 73 +++++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_inv_key_sched.sv | 158 +++++++++++++++
 tb/tb_aes_inv_key_sched.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse key schedule: S-box, RCON, FSM states.
// InvMixColumns helpers are compiled only when AES_INV_EQ_KEY_EN is defined.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2,
        STREAM = 2'd3
    } state_t;

    // Round constants indexed by the round being produced (1..10).
    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

`ifdef AES_INV_EQ_KEY_EN
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of InvMixColumns, bytes big-endian within the word.
    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] a   [4];
        logic [7:0] m9  [4];
        logic [7:0] mb  [4];
        logic [7:0] md  [4];
        logic [7:0] me  [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = sbox(din);

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 key schedule that expands forward into a round-key store and streams keys 10..0.
// Define AES_INV_EQ_KEY_EN to emit InvMixColumns'd keys for rounds 1..9 (equivalent inverse cipher).
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] KEY,
    input  logic             fsm_en,
    input  logic             dec_start,
    output logic             busy,
    output logic             key_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_round,
    output logic             rk_valid,
    output logic             rk_last
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic [KEY_W-1:0] work_reg;
    logic [KEY_W-1:0] store_reg [0:NR];
    logic             busy_reg;
    logic             key_ready_reg;
    logic [KEY_W-1:0] rk_out_reg;
    logic [3:0]       rk_round_reg;
    logic             rk_valid_reg;
    logic             rk_last_reg;

    logic [31:0]      rot_word;
    logic [31:0]      sub_word;
    logic [31:0]      temp_word;
    logic [KEY_W-1:0] next_key;
    logic [3:0]       rd_idx;
    logic [KEY_W-1:0] stream_key;

    // RotWord of the last word of the previous round key, then SubWord.
    assign rot_word = {work_reg[23:0], work_reg[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .din  (rot_word[8*gi +: 8]),
                .dout (sub_word[8*gi +: 8])
            );
        end
    endgenerate

    assign temp_word = sub_word ^ {RCON[cnt_reg], 24'h000000};

    always_comb begin
        logic [31:0] acc;
        next_key = '0;
        acc      = temp_word;
        for (int i = 0; i < 4; i++) begin
            acc = acc ^ work_reg[KEY_W-1-32*i -: 32];
            next_key[KEY_W-1-32*i -: 32] = acc;
        end
    end

    // Index of the key presented on the next beat: 10 at stream start, then counting down.
    always_comb begin
        rd_idx = LAST_ROUND;
        if (state_reg == STREAM)
            rd_idx = (rk_round_reg == 4'd0) ? 4'd0 : rk_round_reg - 4'd1;
    end

`ifdef AES_INV_EQ_KEY_EN
    always_comb begin
        stream_key = store_reg[rd_idx];
        if (rd_idx != 4'd0 && rd_idx != LAST_ROUND) begin
            for (int i = 0; i < 4; i++)
                stream_key[KEY_W-1-32*i -: 32] = inv_mix_word(store_reg[rd_idx][KEY_W-1-32*i -: 32]);
        end
    end
`else
    assign stream_key = store_reg[rd_idx];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            work_reg      <= '0;
            busy_reg      <= 1'b0;
            key_ready_reg <= 1'b0;
            rk_out_reg    <= '0;
            rk_round_reg  <= '0;
            rk_valid_reg  <= 1'b0;
            rk_last_reg   <= 1'b0;
            for (int i = 0; i <= NR; i++)
                store_reg[i] <= '0;
        end else if (fsm_en && state_reg != EXPAND) begin
            // A new key restarts from any non-expanding state, aborting a stream if one runs.
            store_reg[0]  <= KEY;
            work_reg      <= KEY;
            cnt_reg       <= 4'd1;
            state_reg     <= EXPAND;
            busy_reg      <= 1'b1;
            key_ready_reg <= 1'b0;
            rk_valid_reg  <= 1'b0;
            rk_last_reg   <= 1'b0;
        end else begin
            case (state_reg)
                EXPAND: begin
                    store_reg[cnt_reg] <= next_key;
                    work_reg           <= next_key;
                    if (cnt_reg == LAST_ROUND) begin
                        state_reg     <= READY;
                        busy_reg      <= 1'b0;
                        key_ready_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                READY: begin
                    if (dec_start) begin
                        state_reg     <= STREAM;
                        busy_reg      <= 1'b1;
                        key_ready_reg <= 1'b0;
                        rk_out_reg    <= stream_key;
                        rk_round_reg  <= LAST_ROUND;
                        rk_valid_reg  <= 1'b1;
                        rk_last_reg   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (rk_round_reg == 4'd0) begin
                        state_reg     <= READY;
                        busy_reg      <= 1'b0;
                        key_ready_reg <= 1'b1;
                        rk_valid_reg  <= 1'b0;
                        rk_last_reg   <= 1'b0;
                    end else begin
                        rk_out_reg   <= stream_key;
                        rk_round_reg <= rd_idx;
                        rk_last_reg  <= (rd_idx == 4'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = busy_reg;
    assign key_ready = key_ready_reg;
    assign rk_out    = rk_out_reg;
    assign rk_round  = rk_round_reg;
    assign rk_valid  = rk_valid_reg;
    assign rk_last   = rk_last_reg;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched against a GF(2^8)-arithmetic AES key-expansion model.
module tb_aes_inv_key_sched;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] FIPS_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key = '0;
    logic         fsm_en = 1'b0;
    logic         dec_start = 1'b0;
    logic         busy, key_ready, rk_valid, rk_last;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;

    int checks = 0;
    int errors = 0;

    logic [127:0] ref_rk [0:10];

    always #5 clk = ~clk;

    aes_inv_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .KEY       (key),
        .fsm_en    (fsm_en),
        .dec_start (dec_start),
        .busy      (busy),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_last   (rk_last)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_invmix(input logic [127:0] k);
        logic [127:0] r = '0;
        logic [7:0]   a [4];
        logic [7:0]   coef [4];
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = k[127 - 32*c - 8*i -: 8];
            for (int i = 0; i < 4; i++) begin
                logic [7:0] s = 8'h00;
                for (int j = 0; j < 4; j++) s ^= gmul(a[(i + j) % 4], coef[j]);
                r[127 - 32*c - 8*i -: 8] = s;
            end
        end
        return r;
    endfunction

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] exp_beat(input int r);
        logic [127:0] k = ref_rk[r];
`ifdef AES_INV_EQ_KEY_EN
        if (r >= 1 && r <= 9) k = ref_invmix(k);
`endif
        return k;
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fsm_en(input logic [127:0] k);
        key = k; fsm_en = 1'b1;
        tick();
        fsm_en = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (key_ready !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout key_ready=%b required 1 within 30 cycles", name, key_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({busy, key_ready, rk_valid, rk_last, rk_round, rk_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b ready=%b valid=%b last=%b round=%0d out=%h required all 0",
                     busy, key_ready, rk_valid, rk_last, rk_round, rk_out);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        $display("reset: outputs cleared");
    endtask

    task automatic test_dec_start_idle();
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_dec_start cycle %0d valid=%b busy=%b ready=%b required 0 0 0",
                         i, rk_valid, busy, key_ready);
            end
            tick();
        end
        $display("idle: dec_start ignored");
    endtask

    task automatic test_expansion(input logic [127:0] k);
        pulse_fsm_en(k);
        model_expand(k);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (busy !== 1'b1 || key_ready !== 1'b0) begin
                errors++;
                $display("FAIL expand_busy cycle %0d busy=%b ready=%b required 1 0", c, busy, key_ready);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL expand_done busy=%b ready=%b required 0 1", busy, key_ready);
        end
        $display("expand: key %h", k);
    endtask

    task automatic test_stream(input logic kat);
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if ({rk_valid, rk_round, rk_out, rk_last, busy, key_ready} !==
                {1'b1, 4'(r), exp_beat(r), (r == 0), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stream_beat r=%0d valid=%b round=%0d out=%h last=%b busy=%b ready=%b required out=%h",
                         r, rk_valid, rk_round, rk_out, rk_last, busy, key_ready, exp_beat(r));
            end
            if (kat && r == 10) begin
                checks++;
                if (rk_out !== FIPS_R10) begin
                    errors++;
                    $display("FAIL kat_round10 out=%h required %h", rk_out, FIPS_R10);
                end
            end
`ifndef AES_INV_EQ_KEY_EN
            if (kat && r == 1) begin
                checks++;
                if (rk_out !== FIPS_R1) begin
                    errors++;
                    $display("FAIL kat_round1 out=%h required %h", rk_out, FIPS_R1);
                end
            end
`endif
            if (kat && r == 0) begin
                checks++;
                if (rk_out !== FIPS_KEY || rk_last !== 1'b1) begin
                    errors++;
                    $display("FAIL kat_round0 out=%h last=%b required %h 1", rk_out, rk_last, FIPS_KEY);
                end
            end
            tick();
        end
        checks++;
        if (rk_valid !== 1'b0 || rk_last !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_end valid=%b last=%b ready=%b busy=%b required 0 0 1 0",
                     rk_valid, rk_last, key_ready, busy);
        end
        $display("stream: 11 beats checked");
    endtask

    task automatic test_fsm_en_mid_expand();
        logic [127:0] ka = rand_key();
        logic [127:0] kb = rand_key();
        pulse_fsm_en(ka);
        model_expand(ka);
        tick(); tick(); tick();
        pulse_fsm_en(kb);
        wait_ready("mid_expand");
        test_stream(1'b0);
        $display("mid-expand fsm_en: schedule of first key kept");
    endtask

    task automatic test_abort();
        logic [127:0] kc = rand_key();
        logic [127:0] kd = rand_key();
        logic [127:0] held;
        test_expansion(kc);
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
        tick(); tick(); tick();
        held = exp_beat(7);
        checks++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd7) begin
            errors++;
            $display("FAIL abort_beat4 valid=%b round=%0d required 1 7", rk_valid, rk_round);
        end
        test_expansion(kd);
        checks++;
        if (rk_valid !== 1'b0 || rk_out !== held) begin
            errors++;
            $display("FAIL abort_hold valid=%b out=%h required 0 %h", rk_valid, rk_out, held);
        end
        test_stream(1'b0);
        $display("abort: stream aborted at beat 4, new schedule streamed");
    endtask

    task automatic test_priority();
        logic [127:0] ke = rand_key();
        key = ke; fsm_en = 1'b1; dec_start = 1'b1;
        tick();
        fsm_en = 1'b0; dec_start = 1'b0;
        model_expand(ke);
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b1 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL priority valid=%b busy=%b ready=%b required 0 1 0", rk_valid, busy, key_ready);
        end
        wait_ready("priority");
        test_stream(1'b0);
        $display("priority: fsm_en beat dec_start");
    endtask

    task automatic test_back_to_back();
        test_stream(1'b0);
        test_stream(1'b0);
        $display("back-to-back: replayed stream twice");
    endtask

    task automatic test_reset_mid_stream();
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, key_ready, rk_valid, rk_last, rk_round, rk_out} !== '0) begin
            errors++;
            $display("FAIL async_reset busy=%b ready=%b valid=%b last=%b round=%0d out=%h required all 0",
                     busy, key_ready, rk_valid, rk_last, rk_round, rk_out);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_dec_start cycle %0d valid=%b busy=%b ready=%b required 0 0 0",
                         i, rk_valid, busy, key_ready);
            end
            tick();
        end
        $display("reset mid-stream: cleared, dec_start ignored afterwards");
    endtask

    initial begin
        test_reset();
        test_dec_start_idle();
        test_expansion(FIPS_KEY);
        test_stream(1'b1);
        test_expansion(rand_key());
        test_stream(1'b0);
        test_fsm_en_mid_expand();
        test_abort();
        test_priority();
        test_back_to_back();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
